// File: rtl/mxn_calc_pkg.sv
// Shared types and helpers for the modular-multiplier table generator.
package mxn_calc_pkg;

   typedef enum logic [0:0] {IDLE, CALC} state_t;

   function automatic int clog2(input int v);
      int r;
      for (r = 0; (1 << r) < v; r++) begin
      end
      return r;
   endfunction

endpackage

// File: rtl/mod_add_red.sv
// Modular add with a single conditional subtract: r = (a+b) mod m for a,b < m.
module mod_add_red #(
   parameter int NBITS = 4096
) (
   input  logic [NBITS-1:0] a,
   input  logic [NBITS-1:0] b,
   input  logic [NBITS-1:0] m,
   output logic [NBITS-1:0] r,
   output logic             sum_ge_m
);

   logic [NBITS:0]   s;
   logic [NBITS-1:0] diff;
   logic             borrow;
   logic             d_hi_unused;

   always_comb begin
      s = {1'b0, a} + {1'b0, b};
      // borrow out of the NBITS+2-bit subtract is the s < m indicator
      {borrow, d_hi_unused, diff} = {1'b0, s} - {2'b00, m};
      sum_ge_m = ~borrow;
      r = sum_ge_m ? diff : s[NBITS-1:0];
   end

endmodule

// File: rtl/mxn_calc_v2.sv
// Builds the i*b mod m and i*m tables for the radix-2^PBITS interleaved multiplier.
module mxn_calc_v2
   import mxn_calc_pkg::*;
#(
   parameter  int NBITS  = 4096,
   parameter  int PBITS  = 2,
   localparam int MLSIZE = 1 << PBITS
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic [NBITS-1:0]                     m,
   input  logic [NBITS-1:0]                     b,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 tbl_valid,
   output logic                                 op_err,
   output logic [1:MLSIZE][NBITS+PBITS-1:0]     mxn,
   output logic [0:MLSIZE-1][NBITS-1:0]         bxn
);

   localparam int KW = clog2(MLSIZE + 1);

   state_t                   state;
   logic [NBITS-1:0]         m_q, b_q, bacc, bred;
   logic [NBITS+PBITS-1:0]   macc, macc_nxt;
   logic [KW-1:0]            k;
   logic                     red_ge_unused;

   assign macc_nxt = macc + {{PBITS{1'b0}}, m_q};

   mod_add_red #(.NBITS(NBITS)) u_red (
      .a        (bacc),
      .b        (b_q),
      .m        (m_q),
      .r        (bred),
      .sum_ge_m (red_ge_unused)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         m_q       <= '0;
         b_q       <= '0;
         macc      <= '0;
         bacc      <= '0;
         k         <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         tbl_valid <= 1'b0;
         op_err    <= 1'b0;
         mxn       <= '0;
         bxn       <= '0;
      end else begin
         done <= 1'b0;
         // start has priority over completion, so a coincident start restarts cleanly
         if (start) begin
            state     <= CALC;
            m_q       <= m;
            b_q       <= b;
            mxn[1]    <= {{PBITS{1'b0}}, m};
            bxn[1]    <= b;
            macc      <= {{PBITS{1'b0}}, m};
            bacc      <= b;
            k         <= KW'(2);
            busy      <= 1'b1;
            tbl_valid <= 1'b0;
            op_err    <= (b >= m) | (m == '0);
         end else if (state == CALC) begin
            for (int i = 2; i <= MLSIZE; i++)
               if (k == KW'(i)) mxn[i] <= macc_nxt;
            for (int i = 2; i < MLSIZE; i++)
               if (k == KW'(i)) bxn[i] <= bred;
            macc <= macc_nxt;
            bacc <= bred;
            k    <= k + KW'(1);
            if (k == KW'(MLSIZE)) begin
               state     <= IDLE;
               busy      <= 1'b0;
               done      <= 1'b1;
               tbl_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mxn_calc_v2.sv
// Directed bench: PBITS=2 and PBITS=1 instances, scoreboard of expected tables.
module tb_mxn_calc_v2;

   logic clk, rst_n;
   logic start_a, start_b;
   logic [7:0] m_a, b_a, m_b, b_b;
   logic busy_a, done_a, tv_a, err_a;
   logic busy_b, done_b, tv_b, err_b;
   logic [1:4][9:0] mxn_a;
   logic [0:3][7:0] bxn_a;
   logic [1:2][8:0] mxn_b;
   logic [0:1][7:0] bxn_b;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      logic [1:4][9:0] mxn;
      logic [0:3][7:0] bxn;
      logic            err;
   } exp_t;

   exp_t exp_q[$];

   mxn_calc_v2 #(.NBITS(8), .PBITS(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .m(m_a), .b(b_a),
      .busy(busy_a), .done(done_a), .tbl_valid(tv_a), .op_err(err_a),
      .mxn(mxn_a), .bxn(bxn_a)
   );

   mxn_calc_v2 #(.NBITS(8), .PBITS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .m(m_b), .b(b_b),
      .busy(busy_b), .done(done_b), .tbl_valid(tv_b), .op_err(err_b),
      .mxn(mxn_b), .bxn(bxn_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $error("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      nvec++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input int mm, input int bb);
      exp_t e;
      e.err = (bb >= mm) || (mm == 0);
      for (int i = 1; i <= 4; i++) e.mxn[i] = 10'(i * mm);
      for (int i = 0; i < 4; i++) e.bxn[i] = (mm == 0) ? 8'd0 : 8'((i * bb) % mm);
      return e;
   endfunction

   task automatic launch(input int mm, input int bb);
      start_a = 1'b1;
      m_a = 8'(mm);
      b_a = 8'(bb);
      exp_q.push_back(model(mm, bb));
   endtask

   // called at the negedge where start_a is high; returns at the negedge after done
   task automatic await_a(input string tag, input int lat);
      int cyc;
      exp_t e;
      @(negedge clk);
      start_a = 1'b0;
      chk({tag, " busy"}, 64'(busy_a), 64'd1);
      chk({tag, " early_done"}, 64'(done_a), 64'd0);
      chk({tag, " tv_low"}, 64'(tv_a), 64'd0);
      cyc = 0;
      for (int i = 1; i <= 40 && cyc == 0; i++) begin
         @(negedge clk);
         if (done_a) cyc = i;
      end
      chk({tag, " latency"}, 64'(cyc), 64'(lat));
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, " op_err"}, 64'(err_a), 64'(e.err));
         chk({tag, " tv"}, 64'(tv_a), 64'd1);
         chk({tag, " busy_end"}, 64'(busy_a), 64'd0);
         if (!e.err) begin
            chk({tag, " mxn"}, 64'(mxn_a), 64'(e.mxn));
            chk({tag, " bxn"}, 64'(bxn_a), 64'(e.bxn));
         end
      end
      @(negedge clk);
      chk({tag, " done_pulse"}, 64'(done_a), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      start_a = 1'b0; m_a = '0; b_a = '0;
      start_b = 1'b0; m_b = '0; b_b = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst busy", 64'(busy_a), 64'd0);
      chk("rst done", 64'(done_a), 64'd0);
      chk("rst tv", 64'(tv_a), 64'd0);
      chk("rst err", 64'(err_a), 64'd0);
      chk("rst mxn", 64'(mxn_a), 64'd0);
      chk("rst bxn", 64'(bxn_a), 64'd0);
      chk("rst b mxn", 64'(mxn_b), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      launch(13, 5);
      await_a("m13b5", 3);
      chk("m13b5 const bxn", 64'(bxn_a), 64'h00050a02);
      chk("m13b5 const mxn", 64'(mxn_a), {24'd0, 10'd13, 10'd26, 10'd39, 10'd52});

      launch(255, 254);
      await_a("m255b254", 3);
      chk("m255 const mxn", 64'(mxn_a), {24'd0, 10'd255, 10'd510, 10'd765, 10'd1020});

      // restart on edge 1 supersedes the first run
      launch(13, 5);
      @(negedge clk);
      chk("restart no_done", 64'(done_a), 64'd0);
      exp_q.delete();
      launch(11, 3);
      await_a("restart", 3);

      // start coincident with the completion edge
      launch(13, 5);
      @(negedge clk);
      start_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      exp_q.delete();
      launch(200, 100);
      await_a("coincide", 3);

      launch(7, 9);
      await_a("illegal b>=m", 3);
      launch(0, 0);
      await_a("illegal m0", 3);

      // reset asserted across edge 2
      launch(13, 5);
      @(negedge clk);
      start_a = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst busy", 64'(busy_a), 64'd0);
      chk("midrst done", 64'(done_a), 64'd0);
      chk("midrst tv", 64'(tv_a), 64'd0);
      chk("midrst err", 64'(err_a), 64'd0);
      chk("midrst mxn", 64'(mxn_a), 64'd0);
      chk("midrst bxn", 64'(bxn_a), 64'd0);
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      launch(13, 5);
      await_a("post_rst", 3);

      // PBITS=1 degenerate instance
      start_b = 1'b1; m_b = 8'd200; b_b = 8'd150;
      @(negedge clk);
      start_b = 1'b0;
      chk("p1 busy", 64'(busy_b), 64'd1);
      chk("p1 early_done", 64'(done_b), 64'd0);
      @(negedge clk);
      chk("p1 done", 64'(done_b), 64'd1);
      chk("p1 tv", 64'(tv_b), 64'd1);
      chk("p1 err", 64'(err_b), 64'd0);
      chk("p1 mxn", 64'(mxn_b), {46'd0, 9'd200, 9'd400});
      chk("p1 bxn", 64'(bxn_b), 64'h0096);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("p1 idle done", 64'(done_b), 64'd0);
      end
      chk("p1 hold mxn", 64'(mxn_b), {46'd0, 9'd200, 9'd400});
      chk("p1 hold bxn", 64'(bxn_b), 64'h0096);
      chk("p1 hold tv", 64'(tv_b), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/mxn_calc_v2.md
Name: mxn_calc_v2

Overview:
- Precomputes the two lookup tables used by the interleaved modular multiplier for a radix-2^PBITS digit step:
  - bxn[i] = i*b mod m, for i = 0..MLSIZE-1.
  - mxn[i] = i*m, unreduced, for i = 1..MLSIZE.
- Successor to the v1 table generator. Adds a registered operand capture, a busy/done/valid handshake, restart-on-start and an operand-error flag.
- Sits between the operand loader and the digit-serial multiplier datapath.

Parameters:
- NBITS, 4096, modulus and operand width in bits.
- PBITS, 2, digit width in bits; must be >= 1.
- MLSIZE, 1<<PBITS, table depth; localparam, not overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- start  in  1  one-cycle pulse; captures m and b, then (re)starts table computation.
- m  in  NBITS  modulus; sampled only when start=1.
- b  in  NBITS  multiplicand; sampled only when start=1; must satisfy b < m.
- busy  out  1  high while tables are being computed.
- done  out  1  one-cycle pulse when both tables are complete.
- tbl_valid  out  1  level; tables are coherent and stable for the captured operands.
- op_err  out  1  captured operands were illegal (b >= m or m == 0); valid while tbl_valid=1.
- mxn  out  [NBITS+PBITS-1:0] x [1:MLSIZE]  multiples of m.
- bxn  out  [NBITS-1:0] x [0:MLSIZE-1]  reduced multiples of b.

Behaviour:
- Reset: every output is 0, including all table entries, busy, done, tbl_valid and op_err. State is IDLE.
- States: IDLE, CALC.
  - IDLE -> CALC on start.
  - CALC -> IDLE after the last entry is written.
  - start in CALC restarts from the capture step: new operands are loaded, the counter reloads, and tbl_valid stays 0.
- Capture edge (edge 0, start=1):
  - m_q <= m; b_q <= b.
  - mxn[1] <= m; bxn[1] <= b. bxn[0] is constant 0.
  - Both accumulators load: macc <= m, bacc <= b.
  - Index counter k <= 2; busy <= 1; tbl_valid <= 0; op_err <= (b >= m) | (m == 0).
- Each CALC edge j (j = 1..MLSIZE-1) writes index k = j+1:
  - mxn[k] <= macc + m_q, computed at NBITS+PBITS bits. It cannot overflow because MLSIZE*(2^NBITS - 1) < 2^(NBITS+PBITS).
  - s = bacc + b_q, computed at NBITS+1 bits. r = (s >= m_q) ? s - m_q : s. The comparison is done on the NBITS+2-bit borrow of s - m_q.
  - bxn[k] <= r only if k < MLSIZE.
  - macc and bacc advance to the new values; k increments.
- Completion: on edge MLSIZE-1, busy <= 0, done <= 1 for exactly one cycle, tbl_valid <= 1.
  - PBITS=1 is the degenerate case: a single CALC edge writes only mxn[2].
- Latency: done is high in the cycle following edge MLSIZE-1, counting the start edge as 0.
- Table entries not yet written in the current run hold their previous values; they are only meaningful when tbl_valid=1.
- With op_err=1, table contents are unspecified, but the sequencing and timing above are unchanged.
- start coincident with completion: start wins. done stays 0, the run restarts, and tbl_valid stays 0.
- Reset asserted mid-run: immediate return to the reset state; tables are cleared.
- Table outputs are registers, with no combinational path from inputs to any output.

Decomposition:
- Package mxn_calc_pkg:
  - state enum (IDLE, CALC).
  - function clog2 for sizing the counter to PBITS+1 bits.
- Sub-module mod_add_red:
  - Parameter NBITS.
  - Combinational a + b followed by a conditional subtract of m; outputs r and a sum_ge_m flag.
  - Reused by the multiplier datapath.

Test Plan:
- NBITS=8, PBITS=2, start with m=13, b=5 -> bxn = {0,5,10,2}; mxn = {13,26,39,52}; done high in the cycle after edge 3; op_err=0; tbl_valid=1.
- NBITS=8, PBITS=2, m=255, b=254 -> bxn = {0,254,253,252}; mxn = {255,510,765,1020}. Checks the reduce-on-every-step path and the full mxn width.
- Restart: start(m=13,b=5), then start(m=11,b=3) on edge 1 -> no done for the first run; bxn = {0,3,6,9}, mxn = {11,22,33,44}; done 3 cycles after the second start.
- Illegal operands: m=7, b=9 -> op_err=1 with done. Then start(m=0, b=0) -> op_err=1.
- Reset mid-run: rst_n low during edge 2 -> all outputs 0, busy=0, no done. A subsequent start(m=13,b=5) produces the first-scenario result.
- PBITS=1, NBITS=8, m=200, b=150 -> bxn = {0,150}; mxn = {200,400}; done one cycle after the start edge; held tables are stable for 20 idle cycles.
